// File: rtl/video_capture_pkg.sv
// Shared definitions for the video capture block: output word formats,
// luma weights and the capture FSM state encoding.
package video_capture_pkg;

    // Output word format selector values
    localparam int FMT_RGB565 = 0;
    localparam int FMT_LUMA   = 1;

    // Luma weights in 1/256 units; they sum to 256, so white maps to 255
    localparam logic [15:0] LUMA_COEF_R = 16'd77;
    localparam logic [15:0] LUMA_COEF_G = 16'd150;
    localparam logic [15:0] LUMA_COEF_B = 16'd29;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CAPT = 2'd1,
        ST_DROP = 2'd2
    } cap_state_e;

endpackage

// File: rtl/video_pix_pack.sv
// Second pipeline stage data path: converts an RGB888 pixel into the 16-bit
// word that is written to the frame FIFO, then registers it.
module video_pix_pack
    import video_capture_pkg::*;
#(
    parameter int PIX_FMT = FMT_LUMA
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  r_i,
    input  logic [7:0]  g_i,
    input  logic [7:0]  b_i,
    output logic [15:0] word_o
);

    logic [15:0] rgb_word;
    logic [15:0] luma_sum;
    logic [15:0] luma_word;
    logic [15:0] word_d;
    logic [15:0] word_q;

    // Build both candidate words; the format parameter picks one.
    // The luma sum never exceeds 255*256, so 16 bits hold it without loss.
    always_comb begin
        rgb_word  = {r_i[7:3], g_i[7:2], b_i[7:3]};
        luma_sum  = LUMA_COEF_R * {8'd0, r_i}
                  + LUMA_COEF_G * {8'd0, g_i}
                  + LUMA_COEF_B * {8'd0, b_i};
        luma_word = luma_sum >> 8;
        word_d    = (PIX_FMT == FMT_LUMA) ? luma_word : rgb_word;
    end

    // Output register, aligned with the FIFO write strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/video_capture.sv
// Capture side of the parallel video interface. A two-stage pipeline
// registers the incoming stream (S1), then decides writes, frame events and
// dimensions (S2). Frames start only on a vs rising edge, so a capture never
// begins part-way through a frame.
module video_capture
    import video_capture_pkg::*;
#(
    parameter int PIX_FMT = FMT_LUMA,
    parameter int DIM_W   = 12,
    parameter int FCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              vid_hs,
    input  logic              vid_vs,
    input  logic              vid_de,
    input  logic [7:0]        vid_r,
    input  logic [7:0]        vid_g,
    input  logic [7:0]        vid_b,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [15:0]       fifo_wr_data,
    output logic              frame_start,
    output logic              frame_done,
    output logic              overflow,
    output logic [DIM_W-1:0]  act_width,
    output logic [DIM_W-1:0]  act_height,
    output logic [FCNT_W-1:0] frame_cnt
);

    // S1 registers
    logic       vid_hs_unused_q;
    logic       vs_q;
    logic       vs_prev_q;
    logic       de_q;
    logic       de_prev_q;
    logic [7:0] r_q;
    logic [7:0] g_q;
    logic [7:0] b_q;
    logic       full_q;

    // S2 state
    cap_state_e        state_q;
    logic              wr_en_q;
    logic              start_q;
    logic              done_q;
    logic              ovf_q;
    logic [FCNT_W-1:0] fcnt_q;
    logic [DIM_W-1:0]  act_w_q;
    logic [DIM_W-1:0]  act_h_q;

    // Dimension counters
    logic [DIM_W-1:0]  line_cnt_q;
    logic [DIM_W-1:0]  last_w_q;
    logic [DIM_W-1:0]  height_q;

    logic vs_rise;
    logic de_fall;

    function automatic logic [DIM_W-1:0] sat_inc(input logic [DIM_W-1:0] v);
        return (v == {DIM_W{1'b1}}) ? v : v + DIM_W'(1);
    endfunction

    // S1: register the raw stream and the FIFO full flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vid_hs_unused_q <= 1'b0;
            vs_q            <= 1'b0;
            vs_prev_q       <= 1'b0;
            de_q            <= 1'b0;
            de_prev_q       <= 1'b0;
            r_q             <= '0;
            g_q             <= '0;
            b_q             <= '0;
            full_q          <= 1'b0;
        end else begin
            vid_hs_unused_q <= vid_hs;
            vs_q            <= vid_vs;
            vs_prev_q       <= vs_q;
            de_q            <= vid_de;
            de_prev_q       <= de_q;
            r_q             <= vid_r;
            g_q             <= vid_g;
            b_q             <= vid_b;
            full_q          <= fifo_full;
        end
    end

    // Line boundaries come from de, not hs
    assign vs_rise = vs_q & ~vs_prev_q;
    assign de_fall = ~de_q & de_prev_q;

    // Width/height measurement; runs in every state, restarts on each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_cnt_q <= '0;
            last_w_q   <= '0;
            height_q   <= '0;
        end else if (vs_rise) begin
            line_cnt_q <= '0;
            last_w_q   <= '0;
            height_q   <= '0;
        end else if (de_q) begin
            line_cnt_q <= sat_inc(line_cnt_q);
        end else if (de_fall) begin
            last_w_q   <= line_cnt_q;
            line_cnt_q <= '0;
            height_q   <= sat_inc(height_q);
        end
    end

    // Capture FSM with registered write strobe, frame pulses and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            fcnt_q  <= '0;
            act_w_q <= '0;
            act_h_q <= '0;
        end else begin
            wr_en_q <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (vs_rise && enable) begin
                        state_q <= ST_CAPT;
                        start_q <= 1'b1;
                    end
                end
                ST_CAPT: begin
                    if (vs_rise) begin
                        done_q  <= 1'b1;
                        act_w_q <= last_w_q;
                        act_h_q <= height_q;
                        fcnt_q  <= fcnt_q + FCNT_W'(1);
                        if (enable) begin
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (de_q) begin
                        if (full_q) begin
                            ovf_q   <= 1'b1;
                            state_q <= ST_DROP;
                        end else begin
                            wr_en_q <= 1'b1;
                        end
                    end
                end
                ST_DROP: begin
                    // The dropped frame is not reported; resync on the next frame
                    if (vs_rise) begin
                        if (enable) begin
                            state_q <= ST_CAPT;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            // clear has priority over a same-cycle overflow or frame count update
            if (clear) begin
                ovf_q  <= 1'b0;
                fcnt_q <= '0;
            end
        end
    end

    video_pix_pack #(
        .PIX_FMT (PIX_FMT)
    ) u_pix_pack (
        .clk    (clk),
        .rst_n  (rst_n),
        .r_i    (r_q),
        .g_i    (g_q),
        .b_i    (b_q),
        .word_o (fifo_wr_data)
    );

    assign fifo_wr_en  = wr_en_q;
    assign frame_start = start_q;
    assign frame_done  = done_q;
    assign overflow    = ovf_q;
    assign act_width   = act_w_q;
    assign act_height  = act_h_q;
    assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture. Two instances share the stimulus: one in
// RGB565 mode, one in luma mode. Frames are 12x6 total with 8x4 active.
module tb_video_capture;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        clear;
    logic        vid_hs;
    logic        vid_vs;
    logic        vid_de;
    logic [7:0]  vid_r;
    logic [7:0]  vid_g;
    logic [7:0]  vid_b;
    logic        fifo_full;

    logic        fifo_wr_en;
    logic [15:0] fifo_wr_data;
    logic        frame_start;
    logic        frame_done;
    logic        overflow;
    logic [11:0] act_width;
    logic [11:0] act_height;
    logic [15:0] frame_cnt;

    logic        l_wr_en;
    logic [15:0] l_wr_data;
    logic        l_frame_start;
    logic        l_frame_done;
    logic        l_overflow;
    logic [11:0] l_act_width;
    logic [11:0] l_act_height;
    logic [15:0] l_frame_cnt;

    video_capture #(.PIX_FMT(0), .DIM_W(12), .FCNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .fifo_full(fifo_full),
        .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .frame_start(frame_start), .frame_done(frame_done), .overflow(overflow),
        .act_width(act_width), .act_height(act_height), .frame_cnt(frame_cnt)
    );

    video_capture #(.PIX_FMT(1), .DIM_W(12), .FCNT_W(16)) dut_l (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
        .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .vid_r(vid_r), .vid_g(vid_g), .vid_b(vid_b), .fifo_full(fifo_full),
        .fifo_wr_en(l_wr_en), .fifo_wr_data(l_wr_data),
        .frame_start(l_frame_start), .frame_done(l_frame_done), .overflow(l_overflow),
        .act_width(l_act_width), .act_height(l_act_height), .frame_cnt(l_frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic [15:0] exp565;
        logic [15:0] explum;
    } vec_t;

    vec_t tbl[8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt, fs_cnt, fd_cnt;

    // Expected write strobe/data, delayed two cycles behind the stimulus
    logic        pipe1_wr, pipe2_wr;
    logic [15:0] pipe1_565, pipe2_565, pipe1_lum, pipe2_lum;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock of stimulus; checks the outputs produced by the inputs of two
    // steps earlier, then applies the new inputs.
    task automatic step(input logic vs, input logic de, input logic full, input logic wr,
                        input logic en, input logic clr,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic [15:0] e565, input logic [15:0] elum);
        @(negedge clk);
        cyc++;
        chk($sformatf("wr_en@%0d", cyc), fifo_wr_en, pipe2_wr);
        chk($sformatf("wr_en_luma@%0d", cyc), l_wr_en, pipe2_wr);
        if (pipe2_wr) begin
            chk($sformatf("data565@%0d", cyc), fifo_wr_data, pipe2_565);
            chk($sformatf("dataluma@%0d", cyc), l_wr_data, pipe2_lum);
        end
        if (fifo_wr_en) wr_cnt++;
        if (frame_start) fs_cnt++;
        if (frame_done) fd_cnt++;
        pipe2_wr  = pipe1_wr;
        pipe2_565 = pipe1_565;
        pipe2_lum = pipe1_lum;
        pipe1_wr  = wr;
        pipe1_565 = e565;
        pipe1_lum = elum;
        vid_vs    = vs;
        vid_de    = de;
        vid_hs    = ~de;
        fifo_full = full;
        enable    = en;
        clear     = clr;
        vid_r     = r;
        vid_g     = g;
        vid_b     = b;
    endtask

    // One 12x6 frame. en_a applies before cycle sw, en_b from it on.
    task automatic frame(input string name, input logic en_a, input logic en_b, input int sw,
                         input logic wr_ok, input int full_at, input int clr_at, input int rst_at,
                         input logic use_tbl, input logic exp_start, input logic exp_done,
                         input logic [15:0] exp_fcnt, input logic exp_ovf, input int exp_nwr);
        int   p;
        logic active;
        p      = 0;
        active = wr_ok;
        wr_cnt = 0;
        fs_cnt = 0;
        fd_cnt = 0;
        for (int idx = 0; idx < 72; idx++) begin
            int          line;
            int          x;
            logic        vs_v;
            logic        de_v;
            logic        blocked;
            logic [7:0]  rr, gg, bb;
            logic [15:0] e5, el;
            line    = idx / 12;
            x       = idx % 12;
            vs_v    = (line == 0) && (x < 2);
            de_v    = (line >= 1) && (line <= 4) && (x < 8);
            blocked = (full_at >= 0) && (p >= full_at);
            if (use_tbl) begin
                rr = tbl[p % 8].r; gg = tbl[p % 8].g; bb = tbl[p % 8].b;
                e5 = tbl[p % 8].exp565; el = tbl[p % 8].explum;
            end else begin
                rr = 8'hF8; gg = 8'hFC; bb = 8'hF8;
                e5 = 16'hFFFF; el = 16'h00FA;
            end
            step(vs_v, de_v, de_v && blocked, active && de_v && !blocked,
                 (idx < sw) ? en_a : en_b, (idx == clr_at), rr, gg, bb, e5, el);
            if (de_v) p++;
            if (idx == 2) begin
                chk({name, " frame_start"}, frame_start, exp_start);
                chk({name, " frame_done"}, frame_done, exp_done);
                chk({name, " frame_cnt"}, frame_cnt, exp_fcnt);
                chk({name, " overflow"}, overflow, exp_ovf);
                if (exp_done) begin
                    chk({name, " act_width"}, act_width, 64'd8);
                    chk({name, " act_height"}, act_height, 64'd4);
                end
            end
            if (idx == rst_at) begin
                #1 rst_n = 1'b0;
                #1;
                chk({name, " rst_outputs"},
                    {fifo_wr_en, fifo_wr_data, frame_start, frame_done, overflow,
                     act_width, act_height, frame_cnt}, 64'd0);
                chk({name, " rst_luma_data"}, l_wr_data, 64'd0);
                pipe1_wr = 1'b0;
                pipe2_wr = 1'b0;
                active   = 1'b0;
            end
            if (idx == rst_at + 1) rst_n = 1'b1;
        end
        chk({name, " start_pulses"}, fs_cnt, exp_start ? 64'd1 : 64'd0);
        chk({name, " done_pulses"}, fd_cnt, exp_done ? 64'd1 : 64'd0);
        chk({name, " write_count"}, wr_cnt, exp_nwr);
        $display("frame %s: writes=%0d frame_cnt=%0d overflow=%0b", name, wr_cnt, frame_cnt, overflow);
    endtask

    initial begin
        // r, g, b, RGB565 word, luma word = (77r+150g+29b)>>8
        tbl[0] = '{8'hF8, 8'hFC, 8'hF8, 16'hFFFF, 16'h00FA};
        tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 16'hFFFF, 16'h00FF};
        tbl[2] = '{8'hFF, 8'h00, 8'h00, 16'hF800, 16'h004C}; // 19635>>8 = 76
        tbl[3] = '{8'h00, 8'h00, 8'h00, 16'h0000, 16'h0000};
        tbl[4] = '{8'h00, 8'hFF, 8'h00, 16'h07E0, 16'h0095};
        tbl[5] = '{8'h00, 8'h00, 8'hFF, 16'h001F, 16'h001C};
        tbl[6] = '{8'h12, 8'h34, 8'h56, 16'h11AA, 16'h002D};
        tbl[7] = '{8'h80, 8'h80, 8'h80, 16'h8410, 16'h0080};

        pipe1_wr = 1'b0; pipe2_wr = 1'b0;
        pipe1_565 = '0; pipe2_565 = '0; pipe1_lum = '0; pipe2_lum = '0;
        rst_n = 1'b0; enable = 1'b0; clear = 1'b0;
        vid_hs = 1'b0; vid_vs = 1'b0; vid_de = 1'b0;
        vid_r = '0; vid_g = '0; vid_b = '0; fifo_full = 1'b0;
        wr_cnt = 0; fs_cnt = 0; fd_cnt = 0;

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {fifo_wr_en, fifo_wr_data, frame_start, frame_done, overflow,
             act_width, act_height, frame_cnt}, 64'd0);
        chk("reset_luma_outputs", {l_wr_en, l_wr_data, l_frame_cnt}, 64'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, 8'h0, 8'h0, 8'h0, 16'h0, 16'h0);

        //     name  en_a en_b sw  wr  full clr rst tbl start done fcnt ovf nwr
        frame("A",   1,   1,   0,  1,  -1,  -1, -1, 0,  1,    0,   0,   0,  32);
        frame("B",   1,   1,   0,  1,  -1,  -1, -1, 1,  1,    1,   1,   0,  32);
        frame("C",   1,   1,   0,  1,   9,  -1, -1, 0,  1,    1,   2,   0,  9);
        frame("D",   1,   1,   0,  1,  -1,  -1, -1, 1,  1,    0,   2,   1,  32);
        frame("E",   1,   1,   0,  1,  -1,   1, -1, 0,  1,    1,   0,   0,  32);
        frame("F",   1,   0,  30,  1,  -1,  -1, -1, 0,  1,    1,   1,   0,  32);
        frame("G",   0,   1,  30,  0,  -1,  -1, -1, 0,  0,    1,   2,   0,  0);
        frame("H",   1,   1,   0,  1,  -1,  -1, -1, 1,  1,    0,   2,   0,  32);
        frame("I",   1,   1,   0,  1,  -1,  -1, 27, 0,  1,    1,   3,   0,  10);
        frame("J",   1,   1,   0,  1,  -1,  -1, -1, 0,  1,    0,   0,   0,  32);
        frame("K",   1,   1,   0,  1,  -1,  -1, -1, 1,  1,    1,   1,   0,  32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
